// File: rtl/output_display_ctrl_pkg.sv
// Shared definitions for the output display controller.
//
// Contents:
//   SEG_BLANK   - active-low segment pattern with every segment off
//   num_digits  - number of hex digits needed to show a data word
//   hex_to_seg  - hex nibble to active-low 7-segment pattern (gfedcba order)
//
// Optional feature macro used by the top level: OUTPUT_DISPLAY_LZB_EN

package output_display_ctrl_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // One digit per started nibble, so a 10-bit word needs three digits.
    function automatic int num_digits(input int data_w);
        return (data_w + 3) / 4;
    endfunction

    // Standard common-anode patterns; bit 6 is segment g, bit 0 is segment a.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/output_display_ctrl_hex7seg.sv
// Combinational hex-to-7-segment decoder.
//
// Ports:
//   hex - 4-bit nibble to show
//   seg - active-low segment pattern (gfedcba)

module hex7seg
    import output_display_ctrl_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Pure lookup; the caller registers the result where timing matters.
    assign seg = hex_to_seg(hex);

endmodule

// File: rtl/output_display_ctrl.sv
// Front-panel display controller: snapshots BUS or REG, scans the snapshot
// across a multiplexed hex display, shows the timestep on a dedicated digit,
// mirrors BUS onto LEDs and stretches the instruction-complete pulse.
//
// Ports:
//   Clock, Reset - system clock (rising edge), asynchronous active-high reset
//   BUS, REG     - data sources; PEEKb=1 picks BUS, PEEKb=0 picks REG
//   TIME         - current timestep, shown on THEX
//   HOLD         - freezes the snapshot while the scan keeps running
//   Clr          - instruction-complete strobe that retriggers DONE
//   LEDB         - BUS delayed one cycle
//   THEX         - active-low hex digit for TIME
//   SEG, DIGEN   - scanned digit segments and one-cold digit enable
//   DONE         - stretched completion indicator
//
// Build option: define OUTPUT_DISPLAY_LZB_EN to blank leading zero digits.

module output_display_ctrl
    import output_display_ctrl_pkg::*;
#(
    parameter int DATA_W    = 10,
    parameter int TIME_W    = 2,
    parameter int SCAN_DIV  = 50000,
    parameter int DONE_HOLD = 25000000,
    localparam int NUM_DIGITS = num_digits(DATA_W)
)(
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [DATA_W-1:0]     BUS,
    input  logic [DATA_W-1:0]     REG,
    input  logic [TIME_W-1:0]     TIME,
    input  logic                  PEEKb,
    input  logic                  HOLD,
    input  logic                  Clr,
    output logic [DATA_W-1:0]     LEDB,
    output logic [6:0]            THEX,
    output logic [6:0]            SEG,
    output logic [NUM_DIGITS-1:0] DIGEN,
    output logic                  DONE
);

    localparam int PAD_W   = NUM_DIGITS * 4;
    localparam int PRESC_W = $clog2(SCAN_DIV);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DCNT_W  = $clog2(DONE_HOLD + 1);

    logic [DATA_W-1:0]  snap;
    logic [PAD_W-1:0]   snap_ext;
    logic [PRESC_W-1:0] presc;
    logic [IDX_W-1:0]   idx;
    logic [DCNT_W-1:0]  done_cnt;
    logic               clr_q;
    logic               clr_rise;
    logic [3:0]         scan_nib;
    logic [6:0]         scan_seg;
    logic [6:0]         time_seg;
    logic               blank;

    // Zero-extending to whole nibbles lets the top digit be read like the others.
    assign snap_ext = PAD_W'(snap);

    // Nibble for the digit currently being scanned.
    always_comb begin
        scan_nib = 4'(snap_ext >> (4 * int'(idx)));
    end

    hex7seg u_scan_dec (
        .hex (scan_nib),
        .seg (scan_seg)
    );

    hex7seg u_time_dec (
        .hex (4'(TIME)),
        .seg (time_seg)
    );

    // A digit is blanked only when it and everything above it is zero, so
    // interior zeros (e.g. 0x205) still show; digit 0 is never blanked.
`ifdef OUTPUT_DISPLAY_LZB_EN
    always_comb begin
        blank = (idx != '0) && ((snap_ext >> (4 * int'(idx))) == '0);
    end
`else
    assign blank = 1'b0;
`endif

    // Snapshot, LED mirror and timestep digit all update every cycle; only the
    // snapshot honours HOLD.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            snap <= '0;
            LEDB <= '0;
            THEX <= SEG_BLANK;
        end else begin
            if (!HOLD) begin
                snap <= PEEKb ? BUS : REG;
            end
            LEDB <= BUS;
            THEX <= time_seg;
        end
    end

    // Prescaler and digit index run freely; nothing but Reset restarts them, so
    // changing the source or freezing the snapshot never disturbs the scan.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PRESC_W'(SCAN_DIV - 1)) begin
            presc <= '0;
            if (idx == IDX_W'(NUM_DIGITS - 1)) begin
                idx <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // SEG and DIGEN are registered from the same index in the same process so
    // the pattern never lands on the wrong digit, even for a single cycle.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            SEG   <= SEG_BLANK;
            DIGEN <= '1;
        end else begin
            SEG   <= blank ? SEG_BLANK : scan_seg;
            DIGEN <= ~(NUM_DIGITS'(1) << idx);
        end
    end

    assign clr_rise = Clr & ~clr_q;

    // DONE stretcher: each new Clr rising edge restarts the full hold time, while
    // a Clr that simply stays high lets the count expire normally.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            clr_q    <= 1'b0;
            done_cnt <= '0;
        end else begin
            clr_q <= Clr;
            if (clr_rise) begin
                done_cnt <= DCNT_W'(DONE_HOLD);
            end else if (done_cnt != '0) begin
                done_cnt <= done_cnt - 1'b1;
            end
        end
    end

    assign DONE = (done_cnt != '0);

endmodule
